// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: VGA reads, full-screen fill and a small
// write FIFO share the single pixel-RAM port (read > fill > FIFO).
module fb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic        vga_clk,
    input  logic        clr,
    input  logic        vga_rdn,
    input  logic [8:0]  vga_row,
    input  logic [9:0]  vga_col,
    output logic [7:0]  vga_data,
    input  logic        wr_valid,
    input  logic [8:0]  wr_row,
    input  logic [9:0]  wr_col,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        fill_start,
    input  logic [7:0]  fill_color,
    output logic        fill_busy,
    output logic        wr_err,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [9:0]  H_LIM    = 10'(H_RES);
    localparam logic [9:0]  V_LIM    = 10'(V_RES);
    localparam logic [9:0]  COL_LAST = 10'(H_RES - 1);
    localparam logic [8:0]  ROW_LAST = 9'(V_RES - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic [7:0] data;
    } wr_entry_t;

    wr_entry_t   fifo_mem [FIFO_DEPTH];
    wr_entry_t   head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        head_ok;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  fill_row;
    logic [9:0]  fill_col;
    logic [7:0]  fill_px;
    logic        fill_we;
    logic        fill_last;
    logic        rd_grant_q;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign head_ok  = ({1'b0, head.row} < V_LIM) && (head.col < H_LIM);

    assign fill_busy = (state == FILL);
    assign fill_we   = (state == FILL) & vga_rdn;
    assign pop       = (state == IDLE) & vga_rdn & ~empty;
    assign fill_last = (fill_row == ROW_LAST) && (fill_col == COL_LAST);

    assign vga_data = rd_grant_q ? mem_rdata : 8'h00;

    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {wr_row, wr_col, wr_data};
        end
    end

    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_err     <= 1'b0;
            rd_grant_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pop && !head_ok) begin
                wr_err <= 1'b1;
            end
            rd_grant_q <= ~vga_rdn;
        end
    end

    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            fill_row <= '0;
            fill_col <= '0;
            fill_px  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && fill_start) begin
                fill_px  <= fill_color;
                fill_row <= '0;
                fill_col <= '0;
            end else if (fill_we) begin
                // Column-first raster walk, wrapping to (0,0) after the last pixel.
                if (fill_col == COL_LAST) begin
                    fill_col <= '0;
                    fill_row <= fill_last ? 9'd0 : fill_row + 9'd1;
                end else begin
                    fill_col <= fill_col + 10'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fill_start) state_nxt = FILL;
            FILL: if (fill_we && fill_last) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = {vga_row, vga_col};
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (fill_we) begin
            mem_addr  = {fill_row, fill_col};
            mem_we    = 1'b1;
            mem_wdata = fill_px;
        end else if (pop && head_ok) begin
            mem_addr  = {head.row, head.col};
            mem_we    = 1'b1;
            mem_wdata = head.data;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: vector table plus scoreboarded RAM-write sequences
// for FIFO ordering, fills, read priority and reset abort.
module tb_fb_arbiter;

    localparam int D = 4;
    localparam int H = 40;
    localparam int V = 30;

    logic        vga_clk = 1'b0;
    logic        clr;
    logic        vga_rdn;
    logic [8:0]  vga_row;
    logic [9:0]  vga_col;
    logic [7:0]  vga_data;
    logic        wr_valid;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        fill_start;
    logic [7:0]  fill_color;
    logic        fill_busy;
    logic        wr_err;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    always #20 vga_clk = ~vga_clk;

    fb_arbiter #(
        .FIFO_DEPTH(D),
        .H_RES(H),
        .V_RES(V)
    ) dut (
        .vga_clk(vga_clk),
        .clr(clr),
        .vga_rdn(vga_rdn),
        .vga_row(vga_row),
        .vga_col(vga_col),
        .vga_data(vga_data),
        .wr_valid(wr_valid),
        .wr_row(wr_row),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .fill_start(fill_start),
        .fill_color(fill_color),
        .fill_busy(fill_busy),
        .wr_err(wr_err),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] ram_f(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0};
    endfunction

    // Synchronous RAM stand-in: fixed content derived from the address.
    always @(posedge vga_clk) mem_rdata <= ram_f(mem_addr);

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [8:0] row;
        logic [9:0] col;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        logic [8:0] row;
        logic [9:0] col;
        logic [7:0] data;
        logic       exp_we;
        logic       exp_err;
    } vec_t;

    wr_t         sb[$];
    ent_t        mf[$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_rd = 1'b0;
    logic [18:0] prev_addr = '0;

    function automatic logic in_rng(input logic [8:0] r, input logic [9:0] c);
        return (int'(r) < V) && (int'(c) < H);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tb_adv();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic tb_sample();
        wr_t        e;
        logic [7:0] exp_vd;
        @(negedge vga_clk);
        exp_vd = (prev_rd && !clr) ? ram_f(prev_addr) : 8'h00;
        chk("vga_data", 32'(vga_data), 32'(exp_vd));
        if (!clr && !vga_rdn) begin
            chk("rd_addr", 32'(mem_addr), 32'({vga_row, vga_col}));
            chk("rd_we", 32'(mem_we), 0);
        end
        if (mem_we) begin
            if (sb.size() == 0) begin
                chk("spurious_we", 32'(mem_we), 0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
        prev_rd   = !vga_rdn && !clr;
        prev_addr = {vga_row, vga_col};
    endtask

    task automatic fifo_step(input logic v, input logic [8:0] r,
                             input logic [9:0] c, input logic [7:0] d,
                             input logic rdn);
        logic acc;
        logic pp;
        logic exp_we;
        int   occ;
        occ        = mf.size();
        wr_valid   = v;
        wr_row     = r;
        wr_col     = c;
        wr_data    = d;
        vga_rdn    = rdn;
        fill_start = 1'b0;
        acc        = v && (occ < D);
        pp         = rdn && (occ > 0);
        exp_we     = pp ? in_rng(mf[0].row, mf[0].col) : 1'b0;
        if (acc && in_rng(r, c)) sb.push_back('{{r, c}, d});
        tb_sample();
        chk("wr_ready", 32'(wr_ready), 32'(occ < D));
        chk("fifo_we", 32'(mem_we), 32'(exp_we));
        if (pp) mf.delete(0);
        if (acc) mf.push_back('{r, c, d});
    endtask

    task automatic push_fill(input logic [7:0] color, input int count);
        int k;
        k = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (k < count) sb.push_back('{{9'(r), 10'(c)}, color});
                k++;
            end
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   n;

        vecs[0] = '{9'd10, 10'd20, 8'hE3, 1'b1, 1'b0};
        vecs[1] = '{9'd0, 10'd0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{9'(V - 1), 10'(H - 1), 8'h55, 1'b1, 1'b0};
        vecs[3] = '{9'd0, 10'(H), 8'hAA, 1'b0, 1'b1};
        vecs[4] = '{9'(V), 10'd0, 8'h11, 1'b0, 1'b1};
        vecs[5] = '{9'd7, 10'd9, 8'h6C, 1'b1, 1'b1};

        clr        = 1'b1;
        vga_rdn    = 1'b1;
        vga_row    = '0;
        vga_col    = '0;
        wr_valid   = 1'b1;
        wr_row     = 9'd1;
        wr_col     = 10'd1;
        wr_data    = 8'h99;
        fill_start = 1'b1;
        fill_color = 8'h77;
        tb_adv();

        // Reset holds everything idle despite active requests.
        repeat (2) begin
            tb_sample();
            chk("rst_busy", 32'(fill_busy), 0);
            chk("rst_err", 32'(wr_err), 0);
            chk("rst_ready", 32'(wr_ready), 1);
            chk("rst_we", 32'(mem_we), 0);
            chk("rst_vga_data", 32'(vga_data), 0);
            tb_adv();
        end
        clr        = 1'b0;
        wr_valid   = 1'b0;
        fill_start = 1'b0;
        tb_sample();
        chk("post_rst_busy", 32'(fill_busy), 0);
        tb_adv();

        // Single writes through the FIFO, including dropped out-of-range ones.
        for (int i = 0; i < 6; i++) begin
            fifo_step(1'b1, vecs[i].row, vecs[i].col, vecs[i].data, 1'b1);
            tb_adv();
            fifo_step(1'b0, '0, '0, '0, 1'b1);
            chk("vec_we", 32'(mem_we), 32'(vecs[i].exp_we));
            tb_adv();
            fifo_step(1'b0, '0, '0, '0, 1'b1);
            chk("vec_err", 32'(wr_err), 32'(vecs[i].exp_err));
            tb_adv();
        end

        // VGA reads starve the FIFO; the fifth push is refused.
        for (int i = 0; i < 5; i++) begin
            vga_row = 9'(100 + i);
            vga_col = 10'(3 * i + 1);
            fifo_step(1'b1, 9'(20 + i), 10'(7 * i), 8'(8'h30 + i), 1'b0);
            tb_adv();
        end
        vga_row = 9'd200;
        vga_col = 10'd300;
        fifo_step(1'b0, '0, '0, '0, 1'b0);
        chk("full_ready", 32'(wr_ready), 0);
        tb_adv();
        for (int i = 0; i < 5; i++) begin
            fifo_step(1'b0, '0, '0, '0, 1'b1);
            tb_adv();
        end
        chk("drain_done", 32'(sb.size()), 0);

        // Push every cycle while popping: occupancy steady, pointers wrap.
        for (int i = 0; i < 10; i++) begin
            fifo_step(1'b1, 9'(i + 1), 10'(2 * i), 8'(8'hA0 + i), 1'b1);
            tb_adv();
        end
        fifo_step(1'b0, '0, '0, '0, 1'b1);
        tb_adv();
        chk("wrap_done", 32'(sb.size()), 0);

        // Full fill, vga_rdn high; a FIFO write queued during it lands after.
        vga_rdn    = 1'b1;
        wr_valid   = 1'b0;
        fill_color = 8'h1C;
        fill_start = 1'b1;
        push_fill(8'h1C, H * V);
        sb.push_back('{{9'd3, 10'd4}, 8'h5A});
        tb_sample();
        chk("fb_pre", 32'(fill_busy), 0);
        tb_adv();
        fill_start = 1'b0;
        wr_valid   = 1'b1;
        wr_row     = 9'd3;
        wr_col     = 10'd4;
        wr_data    = 8'h5A;
        n = 0;
        while (sb.size() > 1 && n < 4 * H * V) begin
            tb_sample();
            if (n == 0) chk("fb_rise", 32'(fill_busy), 1);
            if (n == 0) chk("fill_push_ready", 32'(wr_ready), 1);
            if (sb.size() == 1) chk("fb_last", 32'(fill_busy), 1);
            tb_adv();
            wr_valid   = 1'b0;
            fill_start = (n == 50);
            fill_color = (n == 50) ? 8'hFF : 8'h1C;
            n++;
        end
        fill_start = 1'b0;
        chk("fill_done", 32'(sb.size()), 1);
        tb_sample();
        chk("fb_fall", 32'(fill_busy), 0);
        chk("fifo_after_fill", 32'(mem_we), 1);
        tb_adv();
        chk("fill_sb_empty", 32'(sb.size()), 0);

        // Fill interleaved with VGA reads every other cycle.
        fill_color = 8'h33;
        fill_start = 1'b1;
        vga_rdn    = 1'b1;
        push_fill(8'h33, H * V);
        tb_sample();
        tb_adv();
        fill_start = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 6 * H * V) begin
            vga_rdn = n[0];
            vga_row = 9'(n % 480);
            vga_col = 10'((n * 5) % 640);
            tb_sample();
            tb_adv();
            n++;
        end
        chk("tog_done", 32'(sb.size()), 0);
        vga_rdn = 1'b1;
        tb_sample();
        chk("tog_fb_fall", 32'(fill_busy), 0);
        chk("tog_idle_we", 32'(mem_we), 0);
        tb_adv();

        // Reset mid-fill with three writes pending in the FIFO.
        fill_color = 8'h44;
        fill_start = 1'b1;
        push_fill(8'h44, 1000);
        tb_sample();
        tb_adv();
        fill_start = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 4000) begin
            wr_valid = (n < 3);
            wr_row   = 9'(n);
            wr_col   = 10'(n);
            wr_data  = 8'hC0;
            tb_sample();
            if (n == 3) chk("pending_ready", 32'(wr_ready), 1);
            tb_adv();
            n++;
        end
        wr_valid = 1'b0;
        chk("abort_reached", 32'(sb.size()), 0);
        clr = 1'b1;
        mf.delete();
        tb_sample();
        chk("abort_busy", 32'(fill_busy), 0);
        chk("abort_ready", 32'(wr_ready), 1);
        chk("abort_we", 32'(mem_we), 0);
        tb_adv();
        clr = 1'b0;
        repeat (6) begin
            tb_sample();
            chk("post_abort_we", 32'(mem_we), 0);
            tb_adv();
        end
        chk("post_abort_busy", 32'(fill_busy), 0);
        chk("post_abort_err", 32'(wr_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
